path_replay_ctrl: RTL

Parametrised, synthesizable successor to the bench-side path feeder for the MC core. It double-buffers one day's Monte Carlo path samples per bank and streams them to the core one sample per cycle. It honours the core's `resend` request by replaying the current day up to a configurable number of times, then advances to the next day. It sits between the host load interface and the MC core `in` port, and replaces the hard-coded 256-sample/8-day/one-replay bench sequencing.

---
 rtl/path_replay_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/path_replay_ctrl.sv
// path_replay_ctrl: double-buffered per-day path sample feeder for the MC core.
// The host fills one bank while the other streams one sample per cycle.
// A core resend replays the current day up to MAX_REPLAY times, then advances the day.
// Optional feature macro: PATH_REPLAY_CHECKSUM_EN registers the sum of each complete pass
// on pass_sum. Without the macro, pass_sum is tied to zero.
module path_replay_ctrl #(
  parameter int unsigned WIDTH      = 12,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned NUM_DAYS   = 8,
  parameter int unsigned MAX_REPLAY = 1,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned DayW = (NUM_DAYS > 1) ? $clog2(NUM_DAYS) : 1,
  localparam int unsigned RepW = (MAX_REPLAY > 0) ? $clog2(MAX_REPLAY + 1) : 1,
  localparam int unsigned SumW = WIDTH + $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  output logic            ld_ready,
  input  logic            start,
  input  logic            resend,
  output logic            path_valid,
  output logic [WIDTH-1:0] path_data,
  output logic [DayW-1:0] day,
  output logic [RepW-1:0] replay_cnt,
  output logic            all_done,
  output logic [SumW-1:0] pass_sum
);

  typedef enum logic [2:0] {StIdle, StWaitData, StStream, StHold, StDone} state_e;

  state_e           state_q, state_d;
  logic [1:0]       full_q, full_d;
  logic             fill_bank_q, fill_bank_d;
  logic             stream_bank_q, stream_bank_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DayW-1:0]  day_q, day_d;
  logic [RepW-1:0]  replay_cnt_q, replay_cnt_d;
  logic             all_done_q, all_done_d;
  logic             path_valid_q, path_valid_d;
  logic [WIDTH-1:0] path_data_q, path_data_d;
  logic             ld_ready_q, ld_ready_d;

  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [WIDTH-1:0] rd_data;
  logic             ld_accept;

`ifdef PATH_REPLAY_CHECKSUM_EN
  logic [SumW-1:0]  acc_q, acc_d;
  logic [SumW-1:0]  pass_sum_q, pass_sum_d;
`endif

  assign ld_accept = ld_valid && ld_ready_q;
  assign rd_data   = mem_q[stream_bank_q][rd_ptr_q];

  // Sample storage; contents need no reset since a bank is read only once marked full.
  always_ff @(posedge clk) begin
    if (ld_accept) begin
      mem_q[fill_bank_q][wr_ptr_q] <= ld_data;
    end
  end

  // Next-state: fill side bookkeeping plus the stream/replay FSM.
  always_comb begin
    state_d       = state_q;
    full_d        = full_q;
    fill_bank_d   = fill_bank_q;
    stream_bank_d = stream_bank_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    day_d         = day_q;
    replay_cnt_d  = replay_cnt_q;
    all_done_d    = all_done_q;
    path_valid_d  = 1'b0;
    path_data_d   = path_data_q;
`ifdef PATH_REPLAY_CHECKSUM_EN
    acc_d         = acc_q;
    pass_sum_d    = pass_sum_q;
`endif

    if (ld_accept) begin
      if (wr_ptr_q == PtrW'(DEPTH - 1)) begin
        full_d[fill_bank_q] = 1'b1;
        wr_ptr_d            = '0;
        fill_bank_d         = ~fill_bank_q;
      end else begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = full_q[0] ? StStream : StWaitData;
        end
      end
      StWaitData: begin
        // Uses the registered full flag, so streaming starts the cycle after the fill lands.
        if (full_q[stream_bank_q]) begin
          state_d  = StStream;
          rd_ptr_d = '0;
        end
      end
      StStream, StHold: begin
        if (resend) begin
          // A resend always aborts the current pass; nothing is emitted this cycle.
          rd_ptr_d = '0;
          if (replay_cnt_q < RepW'(MAX_REPLAY)) begin
            replay_cnt_d = replay_cnt_q + RepW'(1);
            state_d      = StStream;
          end else begin
            full_d[stream_bank_q] = 1'b0;
            replay_cnt_d          = '0;
            stream_bank_d         = ~stream_bank_q;
            if (day_q == DayW'(NUM_DAYS - 1)) begin
              state_d    = StDone;
              all_done_d = 1'b1;
            end else begin
              day_d   = day_q + DayW'(1);
              state_d = full_q[~stream_bank_q] ? StStream : StWaitData;
            end
          end
        end else if (state_q == StStream) begin
          path_valid_d = 1'b1;
          path_data_d  = rd_data;
`ifdef PATH_REPLAY_CHECKSUM_EN
          acc_d = (rd_ptr_q == '0) ? SumW'(rd_data) : acc_q + SumW'(rd_data);
          if (rd_ptr_q == PtrW'(DEPTH - 1)) begin
            pass_sum_d = acc_d;
          end
`endif
          if (rd_ptr_q == PtrW'(DEPTH - 1)) begin
            state_d  = StHold;
            rd_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
          end
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    ld_ready_d = ~full_d[fill_bank_d];
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      full_q        <= '0;
      fill_bank_q   <= 1'b0;
      stream_bank_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      day_q         <= '0;
      replay_cnt_q  <= '0;
      all_done_q    <= 1'b0;
      path_valid_q  <= 1'b0;
      path_data_q   <= '0;
      ld_ready_q    <= 1'b0;
`ifdef PATH_REPLAY_CHECKSUM_EN
      acc_q         <= '0;
      pass_sum_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      full_q        <= full_d;
      fill_bank_q   <= fill_bank_d;
      stream_bank_q <= stream_bank_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      day_q         <= day_d;
      replay_cnt_q  <= replay_cnt_d;
      all_done_q    <= all_done_d;
      path_valid_q  <= path_valid_d;
      path_data_q   <= path_data_d;
      ld_ready_q    <= ld_ready_d;
`ifdef PATH_REPLAY_CHECKSUM_EN
      acc_q         <= acc_d;
      pass_sum_q    <= pass_sum_d;
`endif
    end
  end

  assign ld_ready   = ld_ready_q;
  assign path_valid = path_valid_q;
  assign path_data  = path_data_q;
  assign day        = day_q;
  assign replay_cnt = replay_cnt_q;
  assign all_done   = all_done_q;
`ifdef PATH_REPLAY_CHECKSUM_EN
  assign pass_sum   = pass_sum_q;
`else
  assign pass_sum   = '0;
`endif

endmodule
